aes_128_addkey: RTL and testbench
=================================

# aes_128_addkey

AES-128 AddRoundKey stage with on-the-fly key expansion. It sits directly downstream of the MixColumns stage and XORs each incoming 128-bit state with the current round key. It generates round keys 1..10 internally from the cipher key, one per accepted round, and tells the round controller when the final round (MixColumns bypass) is due. Round 0 is the initial AddRoundKey on the plaintext and is performed on `start`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock, rising edge
- `kill`  in  1  reset; synchronous, active-high; clears all state and outputs
- `start`  in  1  begin new block: load `key_in`, XOR `in_data` (plaintext) with `key_in`
- `key_in`  in  128  cipher key; sampled only on `start`
- `in_valid`  in  1  `in_data` holds the MixColumns output for the next round; accepted only in RUN
- `in_data`  in  128  state input (plaintext on `start`, round state otherwise)
- `out_data`  out  128  registered state after AddRoundKey
- `out_valid`  out  1  one-cycle pulse: `out_data` updated this cycle
- `out_round`  out  4  round index of `out_data` (0..10)
- `out_last`  out  1  with `out_valid`: `out_data` is ciphertext (round 10)
- `final_rnd`  out  1  registered; high while the next accepted input is round 10 (controller drives MixColumns bypass from it)
- `busy`  out  1  high in RUN

Byte packing: column c = bits [32c+31:32c], row r of that column = bits [32c+8r+7:32c+8r]. FIPS-197 byte k maps to bits [8k+7:8k]. The same packing applies to `key_in`: word w_c = bits [32c+31:32c].

## Operation
- Registers: `key_r` (128, current round key), `rcon_r` (8), `rnd_r` (4), FSM state.
- FSM states:
  - IDLE: `in_valid` is ignored.
  - `start` → RUN. On `start`: `out_data`=`in_data`^`key_in`, `key_r`=`key_in`, `rcon_r`=8'h01, `rnd_r`=0, `out_round`=0, `out_valid`=1, `out_last`=0.
  - RUN: on `in_valid`, compute `nk`=expand(`key_r`,`rcon_r`), then `out_data`=`in_data`^`nk`, `key_r`=`nk`, `rcon_r`=xtime(`rcon_r`), `rnd_r`++, `out_round`=new `rnd_r`, `out_valid`=1.
  - When the new `rnd_r`=10: `out_last`=1, state → IDLE.
- expand:
  - t = SubWord(RotWord(w3)) ^ {24'h0, `rcon_r`}.
  - RotWord(w) = {w[7:0], w[31:8]}.
  - SubWord applies the AES forward S-box to each byte (4 parallel S-boxes; table or composite-field, combinational).
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 0). Resulting rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- `final_rnd` = RUN && `rnd_r`==9, registered; updates in the same cycle as `rnd_r`.
- `busy` = (state==RUN).
- Priority: `kill` > `start` > `in_valid`. A `start` in RUN aborts the current block and restarts at round 0; that cycle's `in_valid` is discarded.
- `kill` at any time:
  - All outputs go to 0, `key_r`=0, `rcon_r`=8'h01, `rnd_r`=0, state IDLE.
  - An in-flight block is abandoned.
- `out_data` holds its value between pulses. `out_round` and `out_last` hold until the next update. `out_last` clears on the next `out_valid`.

## Timing
- Latency: 1 cycle from accept (`start` or `in_valid`) to `out_valid`/`out_data`.
- Throughput: one round per cycle. Back-to-back `in_valid` is legal, giving a full block in 11 cycles (`start` + 10 rounds).
- Gaps in `in_valid` stall the key schedule; `key_r` and `rcon_r` hold.
- Reset values: `out_data`=0, `out_valid`=0, `out_round`=0, `out_last`=0, `final_rnd`=0, `busy`=0.
- The combinational path is `key_r` → S-box → XOR chain → `out_data`. No output depends combinationally on an input.

## Test plan
- Zero key, zero plaintext: `start` → `out_data`=0, round 0. Then `in_valid` with `in_data`=0 → `out_data`=rk1 = FIPS bytes 62636363626363636263636362636363, `out_round`=1.
- FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734:
  - round 0 → 193de3bea0f4e22b9ac68d2ae9f84808.
  - `in_valid`, `in_data`=0 → a0fafe1788542cb123a339392a6c7605.
- Full App. B run with the real MixColumns pipeline, back-to-back: 11 `out_valid` pulses. The final pulse gives `out_data`=3925841d02dc09fbdc118597196a0b32, `out_last`=1, `out_round`=10. `final_rnd` is high exactly in the cycle before round 10 is accepted. `busy` drops after the final pulse.
- Stalls: random `in_valid` gaps during the App. B run → identical ciphertext. No `out_valid` in gap cycles.
- `in_valid` in IDLE → no `out_valid`, no state change. `start` at round 5 → restart, round-0 result of the new key. After 10 more rounds → correct new ciphertext.
- `kill` asserted at round 6, and simultaneously with `start` → next cycle all outputs 0, `busy`=0. `start` is ignored in the cycle `kill` is high.

Source files
------------

// File: rtl/aes_128_addkey.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// Round keys 1..10 are derived from key_q one accepted round at a time.
module aes_128_addkey (
    input  logic         clk,
    input  logic         kill,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic [127:0] out_data,
    output logic         out_valid,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         final_rnd,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        // Byte 0 of w3 sits in the low bits, so RotWord is a right rotate by one byte.
        t  = sub_word({k[103:96], k[127:104]}) ^ {24'h0, rc};
        n0 = k[31:0]   ^ t;
        n1 = k[63:32]  ^ n0;
        n2 = k[95:64]  ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    state_t        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    out_round_q, out_round_d;
    logic          out_last_q, out_last_d;
    logic          final_q, final_d;
    logic [127:0]  next_key;

    assign next_key = expand(key_q, rcon_q);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        rcon_d      = rcon_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        final_d     = final_q;
        if (start) begin
            state_d     = RUN;
            key_d       = key_in;
            rcon_d      = 8'h01;
            rnd_d       = '0;
            out_data_d  = in_data ^ key_in;
            out_valid_d = 1'b1;
            out_round_d = '0;
            out_last_d  = 1'b0;
            final_d     = 1'b0;
        end else if (state_q == RUN && in_valid) begin
            key_d       = next_key;
            rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            rnd_d       = rnd_q + 4'd1;
            out_data_d  = in_data ^ next_key;
            out_valid_d = 1'b1;
            out_round_d = rnd_d;
            out_last_d  = (rnd_d == 4'd10);
            final_d     = (rnd_d == 4'd9);
            if (rnd_d == 4'd10) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q     <= IDLE;
            key_q       <= '0;
            rcon_q      <= 8'h01;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            final_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            final_q     <= final_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign final_rnd = final_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_aes_128_addkey.sv
// Directed bench for aes_128_addkey; a reference round model built from
// GF(2^8) arithmetic closes the MixColumns loop around the DUT.
module tb_aes_128_addkey;

    logic         clk = 1'b0;
    logic         kill, start, in_valid;
    logic [127:0] key_in, in_data;
    logic [127:0] out_data;
    logic         out_valid, out_last, final_rnd, busy;
    logic [3:0]   out_round;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    aes_128_addkey dut (
        .clk       (clk),
        .kill      (kill),
        .start     (start),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_round (out_round),
        .out_last  (out_last),
        .final_rnd (final_rnd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIPS-197 hex strings list byte 0 first; the bus carries byte 0 in the low bits.
    function automatic logic [127:0] fips(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] cipher_round(input logic [127:0] s, input bit last);
        logic [127:0] t, o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[32*c + 8*r +: 8] = sb[s[32*((c + r) % 4) + 8*r +: 8]];
        if (last) return t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[32*c +: 8]; a1 = t[32*c + 8 +: 8]; a2 = t[32*c + 16 +: 8]; a3 = t[32*c + 24 +: 8];
            o[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        kill = 1'b1; start = 1'b0; in_valid = 1'b0; key_in = '0; in_data = '0;
        tick(); tick();
        kill = 1'b0;
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL rst_round got %0d exp 0", out_round); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", out_last); end
        checks++; if (final_rnd !== 1'b0) begin errors++; $display("FAIL rst_final got %b exp 0", final_rnd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_key();
        logic [127:0] exp1;
        exp1 = fips(128'h62636363626363636263636362636363);
        key_in = '0; in_data = '0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zk_r0_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL zk_r0_data got %h exp 0", out_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zk_busy got %b exp 1", busy); end
        in_valid = 1'b1; in_data = '0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== exp1) begin errors++; $display("FAIL zk_rk1 got %h exp %h", out_data, exp1); end
        checks++; if (out_round !== 4'd1) begin errors++; $display("FAIL zk_round got %0d exp 1", out_round); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zk_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_fips_round0();
        logic [127:0] exp0, exp1;
        exp0 = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        exp1 = fips(128'ha0fafe1788542cb123a339392a6c7605);
        key_in = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        in_data = fips(128'h3243f6a8885a308d313198a2e0370734);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_data !== exp0) begin errors++; $display("FAIL fb_r0 got %h exp %h", out_data, exp0); end
        checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL fb_r0_round got %0d exp 0", out_round); end
        in_valid = 1'b1; in_data = '0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== exp1) begin errors++; $display("FAIL fb_rk1 got %h exp %h", out_data, exp1); end
    endtask

    task automatic test_full_run(input int max_gap);
        logic [127:0] ct, r0;
        int gap;
        ct = fips(128'h3925841d02dc09fbdc118597196a0b32);
        r0 = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        key_in = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        in_data = fips(128'h3243f6a8885a308d313198a2e0370734);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_data !== r0 || out_valid !== 1'b1) begin errors++; $display("FAIL run_r0 got %h/%b exp %h/1", out_data, out_valid, r0); end
        for (int r = 1; r <= 10; r++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid rnd %0d got %b exp 0", r, out_valid); end
            end
            checks++; if (final_rnd !== (r == 10)) begin errors++; $display("FAIL run_final before rnd %0d got %b exp %b", r, final_rnd, (r == 10)); end
            in_valid = 1'b1;
            in_data = cipher_round(out_data, r == 10);
            tick();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_round !== 4'(r)) begin errors++; $display("FAIL run_pulse got %b/%0d exp 1/%0d", out_valid, out_round, r); end
            checks++; if (out_last !== (r == 10)) begin errors++; $display("FAIL run_last rnd %0d got %b exp %b", r, out_last, (r == 10)); end
        end
        checks++; if (out_data !== ct) begin errors++; $display("FAIL run_ct got %h exp %h", out_data, ct); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got %b exp 0", busy); end
        checks++; if (final_rnd !== 1'b0) begin errors++; $display("FAIL run_final_end got %b exp 0", final_rnd); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL run_hold got %b/%b exp 0/1", out_valid, out_last); end
    endtask

    task automatic test_idle_valid();
        logic [127:0] ct;
        ct = fips(128'h3925841d02dc09fbdc118597196a0b32);
        in_valid = 1'b1; in_data = {4{$urandom}};
        tick(); tick(); tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
        checks++; if (out_data !== ct) begin errors++; $display("FAIL idle_data got %h exp %h", out_data, ct); end
        checks++; if (out_round !== 4'd10) begin errors++; $display("FAIL idle_round got %0d exp 10", out_round); end
    endtask

    task automatic test_restart();
        logic [127:0] r0c, ctc;
        r0c = fips(128'h00102030405060708090a0b0c0d0e0f0);
        ctc = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        key_in = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        in_data = fips(128'h3243f6a8885a308d313198a2e0370734);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            in_valid = 1'b1;
            in_data = cipher_round(out_data, 1'b0);
            tick();
        end
        checks++; if (out_round !== 4'd5) begin errors++; $display("FAIL rs_pre got %0d exp 5", out_round); end
        key_in = fips(128'h000102030405060708090a0b0c0d0e0f);
        in_data = fips(128'h00112233445566778899aabbccddeeff);
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_data !== r0c) begin errors++; $display("FAIL rs_r0 got %h exp %h", out_data, r0c); end
        checks++; if (out_round !== 4'd0 || out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rs_r0_ctl got %0d/%b/%b exp 0/1/1", out_round, out_valid, busy); end
        for (int r = 1; r <= 10; r++) begin
            in_data = cipher_round(out_data, r == 10);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_data !== ctc) begin errors++; $display("FAIL rs_ct got %h exp %h", out_data, ctc); end
        checks++; if (out_last !== 1'b1 || out_round !== 4'd10) begin errors++; $display("FAIL rs_last got %b/%0d exp 1/10", out_last, out_round); end
    endtask

    task automatic test_kill();
        key_in = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        in_data = fips(128'h3243f6a8885a308d313198a2e0370734);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            in_valid = 1'b1;
            in_data = cipher_round(out_data, 1'b0);
            tick();
        end
        kill = 1'b1;
        tick();
        checks++; if (out_data !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL kill_data got %h/%b exp 0/0", out_data, out_valid); end
        checks++; if (out_round !== 4'd0 || out_last !== 1'b0) begin errors++; $display("FAIL kill_round got %0d/%b exp 0/0", out_round, out_last); end
        checks++; if (final_rnd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b/%b exp 0/0", final_rnd, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL kill_start got %b/%b/%h exp 0/0/0", out_valid, busy, out_data); end
        kill = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kill_after got %b/%b exp 0/0", out_valid, busy); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_zero_key();
        test_fips_round0();
        test_full_run(0);
        test_idle_valid();
        test_full_run(3);
        test_restart();
        test_kill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
